// File: rtl/shift_norm_pkg.sv
// rtl/shift_norm_pkg.sv - shared widths, state encoding and direction constants for shift_normalizer
package shift_norm_pkg;

    localparam int WORD_W = 8;
    localparam int AMT_W  = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_normalizer_zero_count8.sv
// rtl/shift_normalizer_zero_count8.sv - zero_count8: combinational leading/trailing-zero priority encoder
module zero_count8
    import shift_norm_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_dir,
    output logic [AMT_W-1:0]  o_count,
    output logic              o_all_zero
);

    // Later loop iterations win, so the scan order picks the priority bit.
    always_comb begin
        o_count = '0;
        if (i_dir == DIR_LEFT) begin
            for (int i = 0; i < WORD_W; i++) begin
                if (i_word[i]) o_count = AMT_W'(WORD_W - 1 - i);
            end
        end else begin
            for (int i = WORD_W - 1; i >= 0; i--) begin
                if (i_word[i]) o_count = AMT_W'(i);
            end
        end
    end

    assign o_all_zero = (i_word == '0);

endmodule

// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - left/right justifies an 8-bit word and reports the shift count; SHIFT_NORM_FAST_EN selects single-cycle normalization
module shift_normalizer
    import shift_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a,
    input  logic              dir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] y,
    output logic [AMT_W-1:0]  amt,
    output logic              zero
);

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_work;
    logic              r_dir;
    logic [AMT_W-1:0]  r_amt;
    logic              r_zero;
    logic              w_accept;
    logic              w_shift_done;

`ifdef SHIFT_NORM_FAST_EN
    logic [AMT_W-1:0]  w_cnt;
    logic              w_all_zero;

    zero_count8 u_zero_count8 (
        .i_word     (r_work),
        .i_dir      (r_dir),
        .o_count    (w_cnt),
        .o_all_zero (w_all_zero)
    );

    assign w_shift_done = 1'b1;
`else
    logic w_target;

    assign w_target     = (r_dir == DIR_LEFT) ? r_work[WORD_W-1] : r_work[0];
    assign w_shift_done = (r_work == '0) || w_target;
`endif

    assign w_accept = in_valid && (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_shift_done) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_dir  <= DIR_LEFT;
            r_amt  <= '0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_work <= a;
            r_dir  <= dir;
            r_amt  <= '0;
            r_zero <= 1'b0;
        end else if (r_state == SHIFT) begin
`ifdef SHIFT_NORM_FAST_EN
            r_work <= (r_dir == DIR_LEFT) ? (r_work << w_cnt) : (r_work >> w_cnt);
            r_amt  <= w_cnt;
            r_zero <= w_all_zero;
`else
            if (r_work == '0) begin
                r_zero <= 1'b1;
                r_amt  <= '0;
            end else if (!w_target) begin
                r_work <= (r_dir == DIR_LEFT) ? (r_work << 1) : (r_work >> 1);
                r_amt  <= r_amt + AMT_W'(1);
            end
`endif
        end
    end

    // The work register doubles as the result; it is only meaningful while out_valid is high.
    assign y    = r_work;
    assign amt  = r_amt;
    assign zero = r_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// tb/tb_shift_normalizer.sv - randomized self-checking bench for shift_normalizer against a behavioural model
module tb_shift_normalizer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic       dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [2:0] amt;
    logic       zero;

    int n_checks;
    int n_errors;

    shift_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .amt       (amt),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the smallest k whose k-fold shift lands a set bit on the target edge.
    task automatic model(input logic [7:0] w, input logic d,
                         output logic [7:0] ey, output logic [2:0] ea, output logic ez);
        logic [7:0] t;
        ey = 8'h00;
        ea = 3'd0;
        ez = (w == 8'h00);
        if (!ez) begin
            for (int k = 7; k >= 0; k--) begin
                t = d ? (w >> k) : (w << k);
                if ((d ? t[0] : t[7]) && ((d ? (t << k) : (t >> k)) == w)) begin
                    ey = t;
                    ea = 3'(k);
                end
            end
        end
    endtask

    function automatic int exp_latency(input logic [2:0] n);
`ifdef SHIFT_NORM_FAST_EN
        return 1;
`else
        return int'(n) + 1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [7:0] w, input logic d);
        in_valid = 1'b1;
        a        = w;
        dir      = d;
        check_eq("in_ready_before_accept", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        a        = 8'($urandom);
        dir      = 1'($urandom);
    endtask

    task automatic wait_result(input string tag, input logic [7:0] w, input logic d);
        logic [7:0] ey;
        logic [2:0] ea;
        logic       ez;
        int         n;
        model(w, d, ey, ea, ez);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check_eq({tag, "_latency"}, n, exp_latency(ea));
        check_eq({tag, "_y"}, y, ey);
        check_eq({tag, "_amt"}, amt, ea);
        check_eq({tag, "_zero"}, zero, ez);
        if (!ez) check_eq({tag, "_inverse"}, d ? (y << amt) : (y >> amt), w);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("out_valid_after_consume", out_valid, 1'b0);
        check_eq("in_ready_after_consume", in_ready, 1'b1);
    endtask

    task automatic run_txn(input string tag, input logic [7:0] w, input logic d);
        do_accept(w, d);
        wait_result(tag, w, d);
        consume();
    endtask

    initial begin
        logic [7:0] w;
        logic       d;
        logic [7:0] hy;
        logic [2:0] ha;
        logic       hz;
        int         stale;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        dir       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_y", y, 8'h00);
        check_eq("rst_amt", amt, 3'd0);
        check_eq("rst_zero", zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_txn("h10_left", 8'h10, 1'b0);
        run_txn("h10_right", 8'h10, 1'b1);
        run_txn("h00_left", 8'h00, 1'b0);
        run_txn("h00_right", 8'h00, 1'b1);
        run_txn("h81_left", 8'h81, 1'b0);
        run_txn("h81_right", 8'h81, 1'b1);
        run_txn("h01_left", 8'h01, 1'b0);
        run_txn("h80_right", 8'h80, 1'b1);

        // Backpressure: result held while a new word is offered.
        do_accept(8'h10, 1'b1);
        wait_result("bp_first", 8'h10, 1'b1);
        hy = y;
        ha = amt;
        hz = zero;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a        = 8'h03;
            dir      = 1'b0;
            step();
            check_eq("bp_out_valid", out_valid, 1'b1);
            check_eq("bp_y_stable", y, hy);
            check_eq("bp_amt_stable", amt, ha);
            check_eq("bp_zero_stable", zero, hz);
            check_eq("bp_in_ready_low", in_ready, 1'b0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("bp_not_accepted_on_handshake", in_ready, 1'b1);
        check_eq("bp_out_valid_dropped", out_valid, 1'b0);
        do_accept(8'h03, 1'b0);
        wait_result("bp_second", 8'h03, 1'b0);
        consume();

        // Reset asserted while SHIFT is in progress.
        do_accept(8'h01, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", in_ready, 1'b1);
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_y", y, 8'h00);
        check_eq("midrst_amt", amt, 3'd0);
        check_eq("midrst_zero", zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("postrst_in_ready", in_ready, 1'b1);
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) stale++;
        end
        check_eq("postrst_no_stale", stale, 0);

        for (int i = 0; i < 60; i++) begin
            w = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d = 1'($urandom);
            do_accept(w, d);
            wait_result("rand", w, d);
            hy = y;
            repeat ($urandom_range(0, 3)) begin
                step();
                check_eq("rand_hold_y", y, hy);
            end
            consume();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
